// File: rtl/tmr_adder_sched_pkg.sv
// Shared types and constants for the TMR adder scheduler.
//   sched_state_e : scheduler FSM states
//   err_cnt_t     : names of the four error-counter slots in err_cnt_o
//   MAX_RETRY_W   : width of the retry counter (MAX_RETRY range 0..7)
//   N_COPY        : number of adder replicas fed by the scheduler
package tmr_adder_sched_pkg;

  localparam int MAX_RETRY_W = 3;
  localparam int N_COPY      = 3;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_e;

  typedef enum logic [1:0] {
    CNT_REP0,
    CNT_REP1,
    CNT_REP2,
    CNT_UNCORR
  } err_cnt_t;

endpackage

// File: rtl/tmr_adder_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request at or after the pointer, wrapping from
// N_REQ-1 back to 0.
//   req   in   N_REQ   request vector
//   ptr   in   IDX_W   index with highest priority this cycle
//   grant out  N_REQ   one-hot grant (all zero when no request)
//   idx   out  IDX_W   index of the granted requester
//   any   out  1       at least one request is asserted
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan N_REQ candidates starting at the pointer; the first hit wins.
  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = (int'(ptr) + off) % N_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/tmr_adder_sched.sv
// Scheduler sharing one triplicated adder and its voter among N_REQ requesters.
// Grants requesters round-robin, drives identical operands to all three
// replicas, retries uncorrectable votes up to MAX_RETRY times and returns the
// voted sum/carry to the owner through a valid/ready response.
// Optional feature: define TMR_ERR_CNT_EN to add saturating per-replica and
// uncorrectable error counters on err_cnt_o; otherwise err_cnt_o is 0.
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o          request handshake, one bit per requester
//   req_a_i/req_b_i/req_cin_i        operands per requester
//   rsp_valid_o/rsp_ready_i          response handshake, one bit per requester
//   rsp_sum_o/rsp_cout_o/rsp_err_o   shared response data
//   add_a_o/add_b_o/add_cin_o        operand copies for replicas 0..2
//   vot_sum_i/vot_cout_i             voted result
//   vot_err_det_i/_corr_i/_any_i     voter error flags
//   cnt_clr_i, err_cnt_o             error counter clear / values
module tmr_adder_sched
  import tmr_adder_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*WIDTH-1:0] req_a_i,
  input  logic [N_REQ*WIDTH-1:0] req_b_i,
  input  logic [N_REQ-1:0]       req_cin_i,
  output logic [N_REQ-1:0]       rsp_valid_o,
  input  logic [N_REQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]       rsp_sum_o,
  output logic                   rsp_cout_o,
  output logic                   rsp_err_o,
  output logic [3*WIDTH-1:0]     add_a_o,
  output logic [3*WIDTH-1:0]     add_b_o,
  output logic [2:0]             add_cin_o,
  input  logic [WIDTH-1:0]       vot_sum_i,
  input  logic                   vot_cout_i,
  input  logic [2:0]             vot_err_det_i,
  input  logic                   vot_err_corr_i,
  input  logic                   vot_err_any_i,
  input  logic                   cnt_clr_i,
  output logic [4*CNT_W-1:0]     err_cnt_o
);

  localparam int IDX_W = $clog2(N_REQ);

  sched_state_e           state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, owner_q, grant_idx;
  logic [N_REQ-1:0]       grant;
  logic                   grant_any;
  logic [MAX_RETRY_W-1:0] retry_q;
  logic                   accept, uncorr, do_retry, rsp_hs;
  logic [WIDTH-1:0]       sel_a, sel_b;
  logic                   sel_cin;
  logic [WIDTH-1:0]       add_a_q [N_COPY];
  logic [WIDTH-1:0]       add_b_q [N_COPY];
  logic                   add_cin_q [N_COPY];
  logic [WIDTH-1:0]       sum_q;
  logic                   cout_q, err_q;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (req_valid_i),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign sel_a   = req_a_i[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_b   = req_b_i[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_cin = req_cin_i[grant_idx];

  // A corrected single-replica error is good data; only detected-but-not-
  // corrected votes count as uncorrectable.
  assign accept   = (state_q == IDLE) && grant_any;
  assign uncorr   = vot_err_any_i & ~vot_err_corr_i;
  assign do_retry = (state_q == EXEC) && uncorr &&
                    (retry_q < MAX_RETRY_W'(MAX_RETRY));
  assign rsp_hs   = (state_q == RESP) && rsp_ready_i[owner_q];

  assign req_ready_o = accept ? grant : '0;
  assign rsp_sum_o   = sum_q;
  assign rsp_cout_o  = cout_q;
  assign rsp_err_o   = err_q;

  // Response valid goes only to the requester that owns the transaction.
  always_comb begin
    rsp_valid_o = '0;
    if (state_q == RESP) rsp_valid_o[owner_q] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: EXEC repeats while retries are allowed, RESP waits for
  // the owner's ready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_any) state_d = EXEC;
      EXEC:    if (!do_retry) state_d = RESP;
      RESP:    if (rsp_hs)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction bookkeeping and response capture. The pointer moves past the
  // owner only once its response has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      owner_q <= '0;
      retry_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        owner_q <= grant_idx;
        retry_q <= '0;
      end
      if (do_retry) retry_q <= retry_q + 1'b1;
      if ((state_q == EXEC) && !do_retry) begin
        sum_q  <= vot_sum_i;
        cout_q <= vot_cout_i;
        err_q  <= uncorr;
      end
      if (rsp_hs) begin
        ptr_q   <= (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        retry_q <= '0;
      end
    end
  end

  // One independent operand register set per replica so a single upset
  // flop affects only one copy and is out-voted.
  for (genvar r = 0; r < N_COPY; r++) begin : g_copy
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        add_a_q[r]   <= '0;
        add_b_q[r]   <= '0;
        add_cin_q[r] <= 1'b0;
      end else if (accept) begin
        add_a_q[r]   <= sel_a;
        add_b_q[r]   <= sel_b;
        add_cin_q[r] <= sel_cin;
      end
    end
    assign add_a_o[r*WIDTH +: WIDTH] = add_a_q[r];
    assign add_b_o[r*WIDTH +: WIDTH] = add_b_q[r];
    assign add_cin_o[r]              = add_cin_q[r];
  end

`ifdef TMR_ERR_CNT_EN
  logic [3:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_q [4];

  // Every EXEC cycle is a voter sample, including retried ones.
  always_comb begin
    cnt_inc = '0;
    if (state_q == EXEC) begin
      cnt_inc[2:0]                = vot_err_det_i;
      cnt_inc[int'(CNT_UNCORR)]   = uncorr;
    end
  end

  // Saturating counters; clear wins over a simultaneous increment.
  for (genvar k = 0; k < 4; k++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            cnt_q[k] <= '0;
      else if (cnt_clr_i)                    cnt_q[k] <= '0;
      else if (cnt_inc[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + 1'b1;
    end
    assign err_cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_clr_i, vot_err_det_i};
  assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_tmr_adder_sched.sv
// Directed self-checking bench for tmr_adder_sched (N_REQ=4, WIDTH=32,
// MAX_RETRY=2, CNT_W=2). The bench models the external adder from replica 0's
// operands and drives the voter error flags directly.
module tb_tmr_adder_sched;

  localparam int N_REQ     = 4;
  localparam int WIDTH     = 32;
  localparam int MAX_RETRY = 2;
  localparam int CNT_W     = 2;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic [N_REQ*WIDTH-1:0] req_a_i;
  logic [N_REQ*WIDTH-1:0] req_b_i;
  logic [N_REQ-1:0]       req_cin_i;
  logic [N_REQ-1:0]       rsp_valid_o;
  logic [N_REQ-1:0]       rsp_ready_i;
  logic [WIDTH-1:0]       rsp_sum_o;
  logic                   rsp_cout_o;
  logic                   rsp_err_o;
  logic [3*WIDTH-1:0]     add_a_o;
  logic [3*WIDTH-1:0]     add_b_o;
  logic [2:0]             add_cin_o;
  logic [WIDTH-1:0]       vot_sum_i;
  logic                   vot_cout_i;
  logic [2:0]             vot_err_det_i;
  logic                   vot_err_corr_i;
  logic                   vot_err_any_i;
  logic                   cnt_clr_i;
  logic [4*CNT_W-1:0]     err_cnt_o;

  logic [WIDTH:0]         model_sum;
  int                     n_checks;
  int                     n_errors;

  tmr_adder_sched #(
    .N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_cin_i(req_cin_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_sum_o(rsp_sum_o), .rsp_cout_o(rsp_cout_o), .rsp_err_o(rsp_err_o),
    .add_a_o(add_a_o), .add_b_o(add_b_o), .add_cin_o(add_cin_o),
    .vot_sum_i(vot_sum_i), .vot_cout_i(vot_cout_i),
    .vot_err_det_i(vot_err_det_i), .vot_err_corr_i(vot_err_corr_i),
    .vot_err_any_i(vot_err_any_i),
    .cnt_clr_i(cnt_clr_i), .err_cnt_o(err_cnt_o)
  );

  // External adder model fed from replica 0.
  assign model_sum  = {1'b0, add_a_o[WIDTH-1:0]} + {1'b0, add_b_o[WIDTH-1:0]}
                    + (WIDTH+1)'(add_cin_o[0]);
  assign vot_sum_i  = model_sum[WIDTH-1:0];
  assign vot_cout_i = model_sum[WIDTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if something hangs beyond every bounded wait.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] act,
                             input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset;
    rst_n          = 1'b0;
    req_valid_i    = '0;
    req_a_i        = '0;
    req_b_i        = '0;
    req_cin_i      = '0;
    rsp_ready_i    = '0;
    vot_err_det_i  = '0;
    vot_err_corr_i = 1'b0;
    vot_err_any_i  = 1'b0;
    cnt_clr_i      = 1'b0;
    tick();
    tick();
    checkOutput("rst_req_ready", req_ready_o, 0);
    checkOutput("rst_rsp_valid", rsp_valid_o, 0);
    checkOutput("rst_rsp_data", {rsp_sum_o, rsp_cout_o, rsp_err_o}, 0);
    checkOutput("rst_add_ops", {add_a_o, add_b_o, add_cin_o}, 0);
    checkOutput("rst_err_cnt", err_cnt_o, 0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic applyStimulus(input int i, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic cin);
    req_a_i[i*WIDTH +: WIDTH] = a;
    req_b_i[i*WIDTH +: WIDTH] = b;
    req_cin_i[i]              = cin;
    req_valid_i[i]            = 1'b1;
  endtask

  // Waits for a grant and consumes the accepting edge; returns -1 on timeout.
  task automatic waitGrant(output int g);
    int c;
    g = -1;
    c = 0;
    while (g < 0 && c < 20) begin
      #1;
      for (int j = 0; j < N_REQ; j++) if (req_ready_o[j]) g = j;
      tick();
      c++;
    end
    if (g < 0) checkOutput("grant_timeout", 1, 0);
  endtask

  // Called in the first EXEC cycle; injects voter flags for the first n_bad
  // EXEC cycles and returns the cycle (accept = 0) at which rsp_valid rose.
  task automatic waitRsp(input int n_bad, input logic corr, input logic [2:0] det,
                         input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                         input logic ec, output int lat);
    logic done;
    lat  = 1;
    done = 1'b0;
    checkOutput("copy_a", add_a_o, {3{ea}});
    checkOutput("copy_b", add_b_o, {3{eb}});
    checkOutput("copy_cin", add_cin_o, {3{ec}});
    while (!done) begin
      vot_err_any_i  = (lat <= n_bad);
      vot_err_corr_i = (lat <= n_bad) ? corr : 1'b0;
      vot_err_det_i  = (lat <= n_bad) ? det : 3'b000;
      #1;
      if (rsp_valid_o != 0 || lat >= 20) done = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    vot_err_any_i  = 1'b0;
    vot_err_corr_i = 1'b0;
    vot_err_det_i  = 3'b000;
    if (rsp_valid_o == 0) checkOutput("rsp_timeout", 0, 1);
  endtask

  task automatic completeRsp(input int g);
    rsp_ready_i    = '0;
    rsp_ready_i[g] = 1'b1;
    tick();
    rsp_ready_i = '0;
    checkOutput("rsp_valid_drop", rsp_valid_o, 0);
  endtask

  initial begin
    int g, lat;
    logic [WIDTH-1:0] t2_sum [4];
    n_checks = 0;
    n_errors = 0;
    t2_sum[0] = 32'h0000_0FF3;
    t2_sum[1] = 32'h0000_10F5;
    t2_sum[2] = 32'h0000_11F5;
    t2_sum[3] = 32'h0000_12F7;

    // 1: single request, clean vote
    applyReset();
    applyStimulus(0, 32'd5, 32'd7, 1'b1);
    waitGrant(g);
    req_valid_i = '0;
    checkOutput("t1_grant", g, 0);
    waitRsp(0, 1'b0, 3'b000, 32'd5, 32'd7, 1'b1, lat);
    checkOutput("t1_latency", lat, 2);
    checkOutput("t1_rsp_valid", rsp_valid_o, 4'b0001);
    checkOutput("t1_rsp", {rsp_sum_o, rsp_cout_o, rsp_err_o}, {32'd13, 1'b0, 1'b0});
    completeRsp(0);

    // 2: all requesters valid, round-robin order 0,1,2,3,0
    applyReset();
    for (int i = 0; i < N_REQ; i++)
      applyStimulus(i, 32'h100 * i + 3, 32'hFF0 + i, i[0]);
    for (int k = 0; k < 5; k++) begin
      waitGrant(g);
      checkOutput("t2_grant", g, k % 4);
      waitRsp(0, 1'b0, 3'b000, 32'h100 * (k % 4) + 3, 32'hFF0 + (k % 4),
              k[0], lat);
      checkOutput("t2_latency", lat, 2);
      checkOutput("t2_sum", rsp_sum_o, t2_sum[k % 4]);
      completeRsp(k % 4);
    end
    req_valid_i = '0;

    // 3: corrected single-replica error is reported as good data
    applyReset();
    applyStimulus(2, 32'hFFFF_FFFF, 32'd1, 1'b0);
    waitGrant(g);
    req_valid_i = '0;
    checkOutput("t3_grant", g, 2);
    waitRsp(1, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'd1, 1'b0, lat);
    checkOutput("t3_latency", lat, 2);
    checkOutput("t3_rsp", {rsp_sum_o, rsp_cout_o, rsp_err_o}, {32'd0, 1'b1, 1'b0});
`ifdef TMR_ERR_CNT_EN
    checkOutput("t3_err_cnt", err_cnt_o, {2'd0, 2'd0, 2'd1, 2'd0});
`else
    checkOutput("t3_err_cnt", err_cnt_o, 0);
`endif
    completeRsp(2);

    // 4a: uncorrectable on all three EXEC cycles -> retries exhausted
    applyStimulus(3, 32'd10, 32'd20, 1'b0);
    waitGrant(g);
    req_valid_i = '0;
    checkOutput("t4a_grant", g, 3);
    waitRsp(3, 1'b0, 3'b000, 32'd10, 32'd20, 1'b0, lat);
    checkOutput("t4a_latency", lat, 4);
    checkOutput("t4a_rsp", {rsp_sum_o, rsp_cout_o, rsp_err_o}, {32'd30, 1'b0, 1'b1});
    completeRsp(3);

    // 4b: transient uncorrectable on the first EXEC cycle only
    applyStimulus(0, 32'd100, 32'd200, 1'b1);
    waitGrant(g);
    req_valid_i = '0;
    checkOutput("t4b_grant", g, 0);
    waitRsp(1, 1'b0, 3'b000, 32'd100, 32'd200, 1'b1, lat);
    checkOutput("t4b_latency", lat, 3);
    checkOutput("t4b_rsp", {rsp_sum_o, rsp_cout_o, rsp_err_o}, {32'd301, 1'b0, 1'b0});
`ifdef TMR_ERR_CNT_EN
    checkOutput("t4_uncorr_cnt", err_cnt_o[3*CNT_W +: CNT_W], 3);
`else
    checkOutput("t4_err_cnt", err_cnt_o, 0);
`endif
    completeRsp(0);

    // 5a: response back-pressure; non-owner readies ignored, no new grant
    applyStimulus(1, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
    waitGrant(g);
    req_valid_i = '0;
    checkOutput("t5_grant", g, 1);
    applyStimulus(0, 32'd1, 32'd1, 1'b0);
    waitRsp(0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1, lat);
    rsp_ready_i = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("t5_hold_valid", rsp_valid_o, 4'b0010);
      checkOutput("t5_hold_data", {rsp_sum_o, rsp_cout_o, rsp_err_o},
                  {32'hEFBE_D001, 1'b0, 1'b0});
      checkOutput("t5_no_grant", req_ready_o, 0);
    end
    completeRsp(1);
    req_valid_i = '0;

    // 5b: reset during EXEC abandons the transaction, pointer back to 0
    applyStimulus(2, 32'd7, 32'd8, 1'b0);
    waitGrant(g);
    req_valid_i = '0;
    checkOutput("t5b_grant", g, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("t5b_rst_rsp", {rsp_valid_o, rsp_sum_o, rsp_cout_o, rsp_err_o}, 0);
    checkOutput("t5b_rst_ops", {add_a_o, add_b_o, add_cin_o}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("t5b_no_rsp", rsp_valid_o, 0);
    for (int i = 0; i < N_REQ; i++) applyStimulus(i, 32'd40 + i, 32'd2, 1'b0);
    waitGrant(g);
    req_valid_i = '0;
    checkOutput("t5b_regrant", g, 0);
    waitRsp(0, 1'b0, 3'b000, 32'd40, 32'd2, 1'b0, lat);
    checkOutput("t5b_sum", rsp_sum_o, 32'd42);
    completeRsp(0);

    // 6: five replica-2 mismatches saturate a 2-bit counter, then clear
    applyReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 32'd3 + k, 32'd4, 1'b0);
      waitGrant(g);
      req_valid_i = '0;
      checkOutput("t6_grant", g, 1);
      waitRsp(1, 1'b1, 3'b100, 32'd3 + k, 32'd4, 1'b0, lat);
      checkOutput("t6_sum", rsp_sum_o, 32'd7 + k);
      completeRsp(1);
    end
`ifdef TMR_ERR_CNT_EN
    checkOutput("t6_sat_cnt", err_cnt_o, {2'd0, 2'd3, 2'd0, 2'd0});
`else
    checkOutput("t6_err_cnt", err_cnt_o, 0);
`endif
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    checkOutput("t6_clr_cnt", err_cnt_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
